fifo_sync_flex: RTL and testbench
=================================

// Module: fifo_sync_flex
// PURPOSE
//  Parametrised synchronous single-clock FIFO for crossbar ingress/egress buffering.
//  Generalises the 4-deep fixed FIFO with configurable depth and data width.
//  Adds selectable read mode: registered-read or first-word-fall-through (FWFT).
//  Also adds occupancy count, almost-full/almost-empty flags and sticky overflow/underflow error flags.
// PARAMETERS
//  DWIDTH     32  data width in bits, >=1
//  DEPTH      16  number of entries; power of 2, >=2
//  FWFT       0   0 = registered read (data 1 cycle after pop); 1 = head word always presented on pop_data
//  AF_THRESH  14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  CW = $clog2(DEPTH)+1 (derived, localparam)
// PORTS
//  aclk          in   1       clock, all logic on rising edge
//  aresetn       in   1       reset, synchronous, active-low
//  push          in   1       write request
//  push_data     in   DWIDTH  write data, sampled with accepted push
//  pop           in   1       read/consume request
//  pop_data      out  DWIDTH  read data (see BEHAVIOUR for mode timing)
//  full          out  1       count == DEPTH
//  not_empty     out  1       a word is available to pop
//  almost_full   out  1       count >= AF_THRESH
//  almost_empty  out  1       count <= AE_THRESH
//  count         out  CW      words stored, 0..DEPTH
//  clr_err       in   1       clears overflow/underflow on next edge
//  overflow      out  1       sticky: push attempted while full
//  underflow     out  1       sticky: pop attempted while not_empty=0
// BEHAVIOUR
//  Reset (aresetn=0 at edge): pointers=0, count=0, full=0, not_empty=0, almost_full=0,
//   almost_empty=1, overflow=0, underflow=0, pop_data=0. Memory contents are not reset.
//  Reset takes effect mid-operation: all stored words are discarded and no accept occurs that edge.
//  Pointers are $clog2(DEPTH)+1 bits; address = low bits; wrap is natural modulo 2*DEPTH.
//  Accept rules use flag values from before the edge:
//   - push_acc = push & ~full
//   - pop_acc = pop & not_empty
//  Full + push + pop: pop accepted, push rejected (overflow set); count -> DEPTH-1.
//  Empty + push + pop: push accepted, pop rejected (underflow set); count -> 1.
//  Push and pop both accepted: count unchanged; data order preserved.
//  count' = count + push_acc - pop_acc. All flags are registered, derived from count'/pointers.
//  All flags are valid the cycle after the edge that changed them.
//  FWFT=0:
//   - pop_acc loads head word into pop_data at the edge, so it is visible the next cycle.
//   - pop_data holds its value otherwise. not_empty = (count != 0).
//   - Push-to-not_empty latency is 1 cycle.
//  FWFT=1:
//   - When not_empty=1, pop_data shows the oldest word combinationally-stable from a register.
//   - pop_acc advances pop_data to the next word on the same edge.
//   - A push into an empty FIFO appears on pop_data with not_empty=1 one cycle later.
//   - count includes the presented word. pop_data value when not_empty=0 is don't-care (holds last).
//  Errors: overflow/underflow set on the offending edge and remain set until clr_err or reset.
//   Set has priority over clr_err on the same edge.
//  No X propagation: pop_data never driven from unwritten memory in either mode.
// TESTING
//  T1 reset: hold aresetn=0 2 cycles -> count=0, not_empty=0, almost_empty=1, flags/errors 0, pop_data=0.
//  T2 fill DEPTH=16: push 0x00..0x0F back-to-back -> full=1 after 16th, almost_full at count 14,
//     17th push -> overflow=1, count stays 16.
//  T3 drain FWFT=0: pop 16 -> pop_data 0x00..0x0F each one cycle after pop; 17th pop -> underflow=1.
//  T4 FWFT=1: push 0xA5 into empty -> next cycle not_empty=1, pop_data=0xA5 with no pop; pop -> not_empty=0.
//  T5 simultaneous push+pop at count 0, 8 and 16 -> counts 1, 8, 15; errors per rules; order intact across 3 wraps.
//  T6 reset at count=9 then clr_err with concurrent overflow -> count=0; overflow remains 1 (set wins).

Source files
------------

// File: rtl/fifo_sync_flex.sv
// Parametrised single-clock FIFO with registered-read or first-word-fall-through output.
// Latency: push to not_empty 1 cycle; registered read shows data 1 cycle after pop; FWFT shows head word once not_empty.
// Backpressure: push ignored while full (sets overflow); pop ignored while empty (sets underflow).
module fifo_sync_flex #(
   parameter int DWIDTH    = 32,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] pop_data,
   output logic              full,
   output logic              not_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CW-1:0]     count,
   input  logic              clr_err,
   output logic              overflow,
   output logic              underflow
);

   localparam int AW = CW - 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     wr_nxt, rd_nxt, count_nxt;
   logic [AW-1:0]     rd_addr_inc;
   logic              push_acc, pop_acc;

   assign push_acc    = push & ~full;
   assign pop_acc     = pop & not_empty;
   assign rd_addr_inc = rd_ptr[AW-1:0] + AW'(1);

   // Next pointers; occupancy falls out of the pointer difference (modulo 2*DEPTH)
   always_comb begin
      wr_nxt = wr_ptr;
      rd_nxt = rd_ptr;
      if (push_acc) wr_nxt = wr_ptr + ONE_C;
      if (pop_acc)  rd_nxt = rd_ptr + ONE_C;
      count_nxt = wr_nxt - rd_nxt;
   end

   // Storage write; contents are never reset and never read before being written
   always_ff @(posedge aclk) begin
      if (aresetn && push_acc) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Pointers and registered status flags, all derived from the post-edge occupancy
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         not_empty    <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= wr_nxt;
         rd_ptr       <= rd_nxt;
         count        <= count_nxt;
         full         <= (count_nxt == DEPTH_C);
         not_empty    <= (count_nxt != '0);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
      end
   end

   // Output word: registered read loads on pop; FWFT keeps the head word presented
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pop_data <= '0;
      end else if (FWFT == 0) begin
         if (pop_acc) pop_data <= mem[rd_ptr[AW-1:0]];
      end else begin
         // The word being pushed becomes head only if the FIFO is left otherwise empty
         if (push_acc && ((count == '0) || (pop_acc && (count == ONE_C))))
            pop_data <= push_data;
         else if (pop_acc && (count > ONE_C))
            pop_data <= mem[rd_addr_inc];
      end
   end

   // Sticky error flags; a new error on the same edge wins over clr_err
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && full)          overflow <= 1'b1;
         else if (clr_err)          overflow <= 1'b0;
         if (pop && !not_empty)     underflow <= 1'b1;
         else if (clr_err)          underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Bench for fifo_sync_flex: one registered-read and one FWFT instance share stimulus.
// A queue model predicts contents, flags and output words every cycle.
// Table vectors cover the short corners; loops cover fill, drain, wrap and reset cases.
module tb_fifo_sync_flex;
   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       push = 1'b0, pop = 1'b0, clr_err = 1'b0;
   logic [7:0] push_data = 8'h00;

   logic [7:0] pd0, pd1;
   logic       full0, ne0, af0, ae0, ovf0, udf0;
   logic       full1, ne1, af1, ae1, ovf1, udf1;
   logic [4:0] cnt0, cnt1;

   fifo_sync_flex #(.DWIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u0 (
      .aclk(aclk), .aresetn(aresetn), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pd0), .full(full0), .not_empty(ne0), .almost_full(af0), .almost_empty(ae0),
      .count(cnt0), .clr_err(clr_err), .overflow(ovf0), .underflow(udf0));

   fifo_sync_flex #(.DWIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u1 (
      .aclk(aclk), .aresetn(aresetn), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pd1), .full(full1), .not_empty(ne1), .almost_full(af1), .almost_empty(ae1),
      .count(cnt1), .clr_err(clr_err), .overflow(ovf1), .underflow(udf1));

   always #5 aclk = ~aclk;

   int         total = 0;
   int         bad = 0;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0, m_udf = 1'b0;
   logic [7:0] m_pd0 = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [31:0] n;
      n = q.size();
      chk("cnt0", 32'(cnt0), n);
      chk("cnt1", 32'(cnt1), n);
      chk("full0", 32'(full0), 32'(n == 16));
      chk("full1", 32'(full1), 32'(n == 16));
      chk("ne0", 32'(ne0), 32'(n != 0));
      chk("ne1", 32'(ne1), 32'(n != 0));
      chk("af0", 32'(af0), 32'(n >= 14));
      chk("af1", 32'(af1), 32'(n >= 14));
      chk("ae0", 32'(ae0), 32'(n <= 2));
      chk("ae1", 32'(ae1), 32'(n <= 2));
      chk("ovf0", 32'(ovf0), 32'(m_ovf));
      chk("ovf1", 32'(ovf1), 32'(m_ovf));
      chk("udf0", 32'(udf0), 32'(m_udf));
      chk("udf1", 32'(udf1), 32'(m_udf));
      chk("pd0", 32'(pd0), 32'(m_pd0));
      if (n != 0) chk("pd1_head", 32'(pd1), 32'(q[0]));
   endtask

   task automatic step(input logic rst, input logic ps, input logic [7:0] d,
                       input logic pp, input logic clr);
      logic pa, oa;
      aresetn   = ~rst;
      push      = ps;
      push_data = d;
      pop       = pp;
      clr_err   = clr;
      @(posedge aclk);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_pd0 = 8'h00;
      end else begin
         pa = ps && (q.size() < 16);
         oa = pp && (q.size() > 0);
         if (ps && !pa) m_ovf = 1'b1;
         else if (clr)  m_ovf = 1'b0;
         if (pp && !oa) m_udf = 1'b1;
         else if (clr)  m_udf = 1'b0;
         if (oa) m_pd0 = q.pop_front();
         if (pa) q.push_back(d);
      end
      #1;
      compare_all();
   endtask

   typedef struct {
      logic       rst, ps;
      logic [7:0] d;
      logic       pp, clr;
      int         e_cnt;
      logic       e_ovf, e_udf;
      logic [7:0] e_pd0;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'hA5};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'hA5};
      tbl[4] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hA5};
      tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'hA5};
      tbl[6] = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h3C};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 8'h5A};

      // reset held two cycles
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
      chk("rst_cnt", 32'(cnt0), 32'd0);
      chk("rst_ae", 32'(ae1), 32'd1);
      chk("rst_pd0", 32'(pd0), 32'd0);
      chk("rst_pd1", 32'(pd1), 32'd0);

      // table: FWFT presentation, empty push+pop, error clear
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].rst, tbl[i].ps, tbl[i].d, tbl[i].pp, tbl[i].clr);
         chk($sformatf("vec%0d_cnt", i), 32'(cnt0), 32'(tbl[i].e_cnt));
         chk($sformatf("vec%0d_ovf", i), 32'(ovf0), 32'(tbl[i].e_ovf));
         chk($sformatf("vec%0d_udf", i), 32'(udf0), 32'(tbl[i].e_udf));
         chk($sformatf("vec%0d_pd0", i), 32'(pd0), 32'(tbl[i].e_pd0));
         if (i == 0) chk("vec0_pd1", 32'(pd1), 32'h0A5);
      end

      // fill 16, overflow, then simultaneous push+pop while full
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 12) chk("af_at13", 32'(af0), 32'd0);
         if (i == 13) chk("af_at14", 32'(af0), 32'd1);
      end
      chk("full_16", 32'(full0), 32'd1);
      step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_17", 32'(ovf0), 32'd1);
      chk("cnt_17", 32'(cnt0), 32'd16);
      step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("full_pp_cnt", 32'(cnt0), 32'd15);
      chk("full_pp_ovf", 32'(ovf1), 32'd1);

      // drain in registered-read mode
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("drain%0d", i), 32'(pd0), 32'(i));
      end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_17", 32'(udf0), 32'd1);

      // simultaneous push+pop at count 8
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
      chk("mid_pp_cnt", 32'(cnt0), 32'd8);
      chk("mid_pp_pd0", 32'(pd0), 32'h080);

      // biased random traffic so pointers wrap several times
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int ph = 0; ph < 10; ph++) begin
         for (int c = 0; c < 40; c++) begin
            logic ps, pp;
            ps = ($urandom_range(0, 3) != 0) ^ ph[0];
            pp = ($urandom_range(0, 3) == 0) ^ ph[0];
            step(1'b0, ps, 8'($urandom), pp, ($urandom_range(0, 15) == 0));
         end
      end

      // reset at count 9, then clear coinciding with a fresh overflow
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      chk("pre_rst_cnt", 32'(cnt0), 32'd9);
      step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      chk("mid_rst_cnt", 32'(cnt1), 32'd0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hDD, 1'b0, 1'b1);
      chk("set_wins", 32'(ovf0), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(ovf0), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
